branch_history_predictor: RTL and testbench
===========================================

Name: branch_history_predictor

Overview:
- Dynamic branch predictor sitting downstream of the ALU.
- Consumes the ALU's resolved branch outcome (Branch_Enable) to train a table of 2-bit saturating counters.
- Answers fetch-stage lookups with a registered taken/not-taken prediction and target.
- Flags mispredictions and supplies the corrected PC to the fetch/PC-select logic.

Parameters:
- INDEX_BITS, 4, table has 2^INDEX_BITS entries, indexed by pc[INDEX_BITS+1:2].
- INIT_STATE, 2'b01, counter value loaded into every entry on reset (weakly not-taken).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- lookup_valid  input  1  fetch presents a branch for prediction.
- lookup_pc  input  32  PC of the branch being fetched.
- lookup_offset  input  32  sign-extended branch immediate.
- predict_valid  output  1  prediction outputs valid, 1 cycle after lookup_valid.
- predict_taken  output  1  predicted direction (counter MSB).
- predict_target  output  32  lookup_pc + lookup_offset, modulo 2^32.
- resolve_valid  input  1  ALU has resolved a branch this cycle.
- resolve_pc  input  32  PC of the resolved branch.
- resolve_taken  input  1  actual outcome (ALU Branch_Enable).
- resolve_predicted  input  1  prediction carried down the pipe with this branch.
- resolve_target  input  32  actual taken target.
- mispredict  output  1  registered; resolved outcome differed from the prediction.
- redirect_pc  output  32  registered; correct next PC when mispredict=1.

Behaviour:
- Reset (async, rst_n=0):
  - all counters = INIT_STATE.
  - predict_valid, predict_taken, mispredict = 0.
  - predict_target, redirect_pc = 0.
  - Takes effect immediately, including mid-operation; any in-flight lookup or resolve is discarded.
- Lookup, 1-cycle latency:
  - On the clk edge: predict_valid <= lookup_valid.
  - If lookup_valid: predict_taken <= effective_counter[idx][1] and predict_target <= lookup_pc + lookup_offset (carry discarded).
  - If lookup_valid=0, predict_taken and predict_target hold their previous values.
- Update, on resolve_valid, at the clk edge, for entry ridx = resolve_pc[INDEX_BITS+1:2]:
  - taken: counter <= (counter==3) ? 3 : counter+1.
  - not taken: counter <= (counter==0) ? 0 : counter-1.
  - Saturation is mandatory; no wrap from 3 to 0 or 0 to 3.
- Mispredict:
  - mispredict <= resolve_valid & (resolve_taken ^ resolve_predicted).
  - redirect_pc <= resolve_taken ? resolve_target : resolve_pc + 32'd4 (mod 2^32).
  - redirect_pc updates whenever resolve_valid=1; otherwise it holds.
  - mispredict is a single-cycle pulse per resolve.
- Simultaneous lookup and resolve:
  - Same index: the lookup uses the post-update counter value (forwarded), so effective_counter is the updated value.
  - Different indices: independent, with no interaction.
- Aliasing: PCs differing only above bit INDEX_BITS+1 share an entry. This is intended; no tags.
- PC bits [1:0] are ignored for indexing.
- No stalls or backpressure; both ports accept one request per cycle.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on each resolve_valid cycle.
  - stat_mispredicts increments on each cycle where mispredict is being set.
  - Both counters wrap modulo 2^32 and are cleared by rst_n.
  - Both are registered and visible the cycle after the event.
- Undefined: the stat ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then lookup pc=0x00000010, offset=0x20: next cycle predict_valid=1, predict_taken=0 (INIT 01), predict_target=0x00000030.
- Three resolves pc=0x10, taken=1, predicted=0, target=0x30: counter goes 01→10→11→11 (saturates). Lookup then gives predict_taken=1. Each resolve gives mispredict=1, redirect_pc=0x30.
- Four resolves pc=0x10, taken=0, predicted=1: counter saturates at 00. mispredict=1 with redirect_pc=0x14 each time. A following lookup gives predict_taken=0.
- Same-cycle lookup and resolve, pc=0x10, counter=01, resolve taken: predict_taken=1 (forwarded value 10).
- Wrap checks:
  - lookup pc=0xFFFFFFF0, offset=0x20 gives predict_target=0x00000010.
  - resolve pc=0xFFFFFFFC, not taken gives redirect_pc=0x00000000.
  - Aliasing: pc=0x10 and pc=0x50 (INDEX_BITS=4) share an entry.
- Assert rst_n low mid-stream with mispredict=1: mispredict and predict_valid drop immediately and counters return to 01. With BRANCH_PREDICTOR_STATS_EN, 5 resolves with 2 mispredicts give stat_branches=5, stat_mispredicts=2, and both clear on reset.

Source files
------------

// File: rtl/branch_history_predictor.sv
// branch_history_predictor: 2-bit saturating-counter predictor with same-index forwarding and mispredict redirect.
// Optional statistics counters are enabled by defining BRANCH_PREDICTOR_STATS_EN.
module branch_history_predictor #(
  parameter int         INDEX_BITS = 4,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_lookup_valid,
  input  logic [31:0] i_lookup_pc,
  input  logic [31:0] i_lookup_offset,
  output logic        o_predict_valid,
  output logic        o_predict_taken,
  output logic [31:0] o_predict_target,
  input  logic        i_resolve_valid,
  input  logic [31:0] i_resolve_pc,
  input  logic        i_resolve_taken,
  input  logic        i_resolve_predicted,
  input  logic [31:0] i_resolve_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0] o_stat_branches,
  output logic [31:0] o_stat_mispredicts
`endif
);
  localparam int N = 1 << INDEX_BITS;
  logic [1:0]            r_ctr [N];
  logic [INDEX_BITS-1:0] w_lidx, w_ridx;
  logic [1:0]            w_cur, w_upd, w_eff;
  logic                  w_mis;
  assign w_lidx = i_lookup_pc[INDEX_BITS+1:2];
  assign w_ridx = i_resolve_pc[INDEX_BITS+1:2];
  assign w_cur  = r_ctr[w_ridx];
  assign w_upd  = i_resolve_taken ? ((w_cur == 2'd3) ? 2'd3 : w_cur + 2'd1)
                                  : ((w_cur == 2'd0) ? 2'd0 : w_cur - 2'd1);
  // a resolve to the same entry in this cycle is forwarded into the lookup
  assign w_eff  = (i_resolve_valid && w_ridx == w_lidx) ? w_upd : r_ctr[w_lidx];
  assign w_mis  = i_resolve_valid & (i_resolve_taken ^ i_resolve_predicted);
  // counter table training on resolved branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_ctr[i] <= INIT_STATE;
    end else if (i_resolve_valid) begin
      r_ctr[w_ridx] <= w_upd;
    end
  end
  // registered prediction for the fetch stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_predict_valid  <= 1'b0;
      o_predict_taken  <= 1'b0;
      o_predict_target <= 32'd0;
    end else begin
      o_predict_valid <= i_lookup_valid;
      if (i_lookup_valid) begin
        o_predict_taken  <= w_eff[1];
        o_predict_target <= i_lookup_pc + i_lookup_offset;
      end
    end
  end
  // mispredict pulse and corrected next PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mispredict  <= 1'b0;
      o_redirect_pc <= 32'd0;
    end else begin
      o_mispredict <= w_mis;
      if (i_resolve_valid) o_redirect_pc <= i_resolve_taken ? i_resolve_target : i_resolve_pc + 32'd4;
    end
  end
`ifdef BRANCH_PREDICTOR_STATS_EN
  // resolved-branch and mispredict event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stat_branches    <= 32'd0;
      o_stat_mispredicts <= 32'd0;
    end else begin
      if (i_resolve_valid) o_stat_branches <= o_stat_branches + 32'd1;
      if (w_mis) o_stat_mispredicts <= o_stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_history_predictor.sv
// tb_branch_history_predictor: randomized and directed checks against a behavioural predictor model.
module tb_branch_history_predictor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        lv, rv, rt, rp;
  logic [31:0] lpc, loff, rpc, rtgt;
  logic        pv, pt, mp;
  logic [31:0] ptgt, rd;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] sb, sm;
  int          e_sb, e_sm;
`endif
  int          m_ctr [16];
  logic        e_pv, e_pt, e_mp;
  logic [31:0] e_tgt, e_rd;
  int          n_cmp = 0, n_bad = 0;

  branch_history_predictor dut (
    .clk(clk), .rst_n(rst_n),
    .i_lookup_valid(lv), .i_lookup_pc(lpc), .i_lookup_offset(loff),
    .o_predict_valid(pv), .o_predict_taken(pt), .o_predict_target(ptgt),
    .i_resolve_valid(rv), .i_resolve_pc(rpc), .i_resolve_taken(rt),
    .i_resolve_predicted(rp), .i_resolve_target(rtgt),
    .o_mispredict(mp), .o_redirect_pc(rd)
`ifdef BRANCH_PREDICTOR_STATS_EN
    , .o_stat_branches(sb), .o_stat_mispredicts(sm)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    check("predict_valid", 32'(pv), 32'(e_pv));
    check("predict_taken", 32'(pt), 32'(e_pt));
    check("predict_target", ptgt, e_tgt);
    check("mispredict", 32'(mp), 32'(e_mp));
    check("redirect_pc", rd, e_rd);
`ifdef BRANCH_PREDICTOR_STATS_EN
    check("stat_branches", sb, 32'(e_sb));
    check("stat_mispredicts", sm, 32'(e_sm));
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    e_pv = 0; e_pt = 0; e_mp = 0; e_tgt = 0; e_rd = 0;
`ifdef BRANCH_PREDICTOR_STATS_EN
    e_sb = 0; e_sm = 0;
`endif
  endtask

  // one clock with the given requests; model predicts, then outputs are compared 1ns after the edge
  task automatic cycle(input logic l_v, input logic [31:0] l_pc, input logic [31:0] l_off,
                       input logic r_v, input logic [31:0] r_pc, input logic r_t, input logic r_p,
                       input logic [31:0] r_tgt);
    int li, ri, nc, eff;
    li = int'(l_pc[5:2]);
    ri = int'(r_pc[5:2]);
    nc = r_t ? ((m_ctr[ri] >= 3) ? 3 : m_ctr[ri] + 1) : ((m_ctr[ri] <= 0) ? 0 : m_ctr[ri] - 1);
    eff = (r_v && li == ri) ? nc : m_ctr[li];
    lv = l_v; lpc = l_pc; loff = l_off;
    rv = r_v; rpc = r_pc; rt = r_t; rp = r_p; rtgt = r_tgt;
    @(posedge clk);
    #1;
    e_pv = l_v;
    if (l_v) begin
      e_pt = (eff >= 2);
      e_tgt = l_pc + l_off;
    end
    e_mp = r_v && (r_t != r_p);
    if (r_v) begin
      e_rd = r_t ? r_tgt : r_pc + 32'd4;
      m_ctr[ri] = nc;
    end
`ifdef BRANCH_PREDICTOR_STATS_EN
    if (r_v) e_sb++;
    if (e_mp) e_sm++;
`endif
    check_all();
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [31:0] off);
    cycle(1, pc, off, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic t, input logic p, input logic [31:0] tgt);
    cycle(0, 0, 0, 1, pc, t, p, tgt);
  endtask

  // asynchronous reset away from the clock edge; outputs must clear without a clock
  task automatic do_reset();
    rst_n = 0;
    lv = 0; lpc = 0; loff = 0; rv = 0; rpc = 0; rt = 0; rp = 0; rtgt = 0;
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    lv = 0; lpc = 0; loff = 0; rv = 0; rpc = 0; rt = 0; rp = 0; rtgt = 0;
    @(posedge clk);
    #1;
    do_reset();
    lookup(32'h10, 32'h20);
    check("tp_first_taken", 32'(pt), 32'd0);
    check("tp_first_target", ptgt, 32'h30);
    for (int i = 0; i < 3; i++) begin
      resolve(32'h10, 1, 0, 32'h30);
      check("tp_taken_mp", 32'(mp), 32'd1);
      check("tp_taken_rd", rd, 32'h30);
    end
    lookup(32'h10, 32'h4);
    check("tp_sat_hi", 32'(pt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      resolve(32'h10, 0, 1, 32'h30);
      check("tp_nt_rd", rd, 32'h14);
    end
    lookup(32'h10, 32'h4);
    check("tp_sat_lo", 32'(pt), 32'd0);
    resolve(32'h10, 1, 0, 32'h30);
    cycle(1, 32'h10, 32'h8, 1, 32'h10, 1, 1, 32'h30);
    check("tp_forward", 32'(pt), 32'd1);
    check("tp_forward_mp", 32'(mp), 32'd0);
    lookup(32'hFFFF_FFF0, 32'h20);
    check("tp_target_wrap", ptgt, 32'h10);
    resolve(32'hFFFF_FFFC, 0, 0, 32'h1234);
    check("tp_redirect_wrap", rd, 32'h0);
    resolve(32'h50, 1, 0, 32'h90);
    lookup(32'h10, 32'h0);
    check("tp_alias_hi", 32'(pt), 32'd1);
    for (int i = 0; i < 3; i++) resolve(32'h50, 0, 1, 32'h90);
    lookup(32'h10, 32'h0);
    check("tp_alias_lo", 32'(pt), 32'd0);
    for (int i = 0; i < 3; i++) resolve(32'h20, 1, 0, 32'h80);
    lookup(32'h20, 32'h0);
    check("tp_pre_reset", 32'(pt), 32'd1);
    resolve(32'h20, 1, 0, 32'h80);
    check("tp_pre_reset_mp", 32'(mp), 32'd1);
    rst_n = 0;
    #1;
    check("tp_rst_mp", 32'(mp), 32'd0);
    check("tp_rst_pv", 32'(pv), 32'd0);
    do_reset();
    resolve(32'h20, 0, 0, 32'h80);
    lookup(32'h20, 32'h0);
    check("tp_ctr_reinit", 32'(pt), 32'd0);
`ifdef BRANCH_PREDICTOR_STATS_EN
    do_reset();
    resolve(32'h10, 1, 0, 32'h30);
    resolve(32'h14, 0, 0, 32'h30);
    resolve(32'h18, 0, 1, 32'h30);
    resolve(32'h1C, 1, 1, 32'h30);
    resolve(32'h10, 0, 0, 32'h30);
    check("tp_stat_br", sb, 32'd5);
    check("tp_stat_mp", sm, 32'd2);
    do_reset();
    check("tp_stat_br_clr", sb, 32'd0);
    check("tp_stat_mp_clr", sm, 32'd0);
`endif
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 3) != 0),
            {$urandom_range(0, 3) == 0 ? $urandom : 32'h0} | 32'($urandom_range(0, 63)),
            1'($urandom), 1'($urandom), $urandom);
    end
    do_reset();
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom, 1'($urandom),
            32'($urandom_range(0, 15)) << 2, 1'($urandom), 1'($urandom), $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
